// File: rtl/interp_block_sequencer.sv
// interp_block_sequencer
// Block-level controller for the 8x8 subpixel interpolation datapath.
// Each block runs four phases: input-row fill, a horizontal FIR pass that
// shifts into the temp registers, a vertical FIR pass with an output
// handshake, and a one-cycle completion pulse.
// Optional feature macro: SEQ_PERF_CNT_EN (enables the output-stall counter).

module interp_block_sequencer #(
  parameter int OUT_ROWS = 8,
  parameter int TAPS     = 8,
  parameter int FIR_LAT  = 2,
  parameter int BLK_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             first_blk_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             load_in_o,
  output logic [3:0]       row_sel_o,
  output logic             h_pass_o,
  output logic             hsr_en_o,
  output logic             pipe_en_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2:0]       out_row_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [BLK_W-1:0] blk_cnt_o,
  output logic [15:0]      stall_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HORIZ,
    S_VERT,
    S_DONE
  } state_t;

  // A first block fills the whole FIR window; later blocks reuse the
  // overlapping TAPS-1 rows and only fetch OUT_ROWS new ones.
  localparam logic [3:0] NEED_FULL = 4'(OUT_ROWS + TAPS - 1);
  localparam logic [3:0] NEED_PART = 4'(OUT_ROWS);
  localparam logic [3:0] LAST_ROW  = 4'(OUT_ROWS - 1);
  localparam logic [3:0] TOP_ROW   = 4'd14;
  localparam logic [4:0] LAT5      = 5'(FIR_LAT);

  state_t           state_q;
  logic [3:0]       need_q;
  logic [3:0]       fill_cnt_q;
  logic [4:0]       hcnt_q;
  logic             iss_vld_q;
  logic [3:0]       row_sel_q;
  logic             h_pass_q;
  logic             hsr_en_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic [BLK_W-1:0] blk_cnt_q;

  // Result delay line: one valid bit and one row index per FIR stage.
  logic             pv_q [FIR_LAT];
  logic [2:0]       pr_q [FIR_LAT];

  logic             load_in;
  logic             stall;
  logic             accept_last;
  logic             pipe_adv;
  logic [4:0]       hcnt_d;
  logic [4:0]       hlast;
  logic             hsr_en_d;
  logic [3:0]       row_sel_d;

  // Handshake qualifiers and HORIZ-phase next-cycle values.
  always_comb begin
    load_in     = in_valid_i & in_ready_q;
    stall       = pv_q[FIR_LAT-1] & ~out_ready_i;
    accept_last = (state_q == S_VERT) & pv_q[FIR_LAT-1] & out_ready_i &
                  (pr_q[FIR_LAT-1] == LAST_ROW[2:0]);
    pipe_adv    = (state_q == S_VERT) & ~stall;
    hlast       = {1'b0, need_q} + LAT5 - 5'd1;
    hcnt_d      = hcnt_q + 5'd1;
    hsr_en_d    = (hcnt_d >= LAT5) && (hcnt_d <= hlast);
    row_sel_d   = (row_sel_q == TOP_ROW) ? TOP_ROW : row_sel_q + 4'd1;
  end

  // Main block sequencer with registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      need_q     <= 4'd0;
      fill_cnt_q <= 4'd0;
      hcnt_q     <= 5'd0;
      iss_vld_q  <= 1'b0;
      row_sel_q  <= 4'd0;
      h_pass_q   <= 1'b0;
      hsr_en_q   <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            need_q     <= first_blk_i ? NEED_FULL : NEED_PART;
            fill_cnt_q <= 4'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_FILL;
          end
        end
        S_FILL: begin
          if (load_in) begin
            fill_cnt_q <= fill_cnt_q + 4'd1;
            if (fill_cnt_q == need_q - 4'd1) begin
              in_ready_q <= 1'b0;
              h_pass_q   <= 1'b1;
              hsr_en_q   <= 1'b0;
              hcnt_q     <= 5'd0;
              row_sel_q  <= 4'd15 - need_q;
              state_q    <= S_HORIZ;
            end
          end
        end
        S_HORIZ: begin
          if (hcnt_q == hlast) begin
            h_pass_q  <= 1'b0;
            hsr_en_q  <= 1'b0;
            hcnt_q    <= 5'd0;
            row_sel_q <= 4'd0;
            iss_vld_q <= 1'b1;
            state_q   <= S_VERT;
          end else begin
            hcnt_q    <= hcnt_d;
            hsr_en_q  <= hsr_en_d;
            row_sel_q <= row_sel_d;
          end
        end
        S_VERT: begin
          if (accept_last) begin
            iss_vld_q <= 1'b0;
            row_sel_q <= 4'd0;
            done_q    <= 1'b1;
            blk_cnt_q <= blk_cnt_q + 1'b1;
            state_q   <= S_DONE;
          end else if (!stall && iss_vld_q) begin
            if (row_sel_q == LAST_ROW) begin
              iss_vld_q <= 1'b0;
            end else begin
              row_sel_q <= row_sel_q + 4'd1;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIR result tracking: advances with the filters, freezes on stall, flushes at block end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIR_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pr_q[i] <= 3'd0;
      end
    end else if (accept_last) begin
      for (int i = 0; i < FIR_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pr_q[i] <= 3'd0;
      end
    end else if (pipe_adv) begin
      pv_q[0] <= iss_vld_q;
      pr_q[0] <= row_sel_q[2:0];
      for (int i = 1; i < FIR_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pr_q[i] <= pr_q[i-1];
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of vertical-pass cycles lost to downstream back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if ((state_q == S_VERT) && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

  assign in_ready_o  = in_ready_q;
  assign load_in_o   = load_in;
  assign row_sel_o   = row_sel_q;
  assign h_pass_o    = h_pass_q;
  assign hsr_en_o    = hsr_en_q;
  assign pipe_en_o   = ~stall;
  assign out_valid_o = pv_q[FIR_LAT-1];
  assign out_row_o   = pr_q[FIR_LAT-1];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign blk_cnt_o   = blk_cnt_q;

endmodule
